// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard
// Decode-stage hazard scoreboard. It tracks in-flight destination registers
// through DEPTH post-decode stages. From these it produces the per-source
// forwarding selects, the decode stall, and a saturating count of stall cycles.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   id_valid_inst   instruction in ID is valid
//   id_src_idx      NUM_SRC packed 5-bit source indices, src k at [5k+4:5k]
//   id_src_used     per-source "actually read" flags
//   id_reg_wr       ID instruction writes rd
//   id_dest_idx     ID destination index
//   id_is_load      ID instruction is a load
//   id_is_mul       ID instruction is a multiply
//   pipe_hold       downstream freeze; the scoreboard does not advance
//   flush           squash the ID instruction
//   fwd_sel         per source: 0 = regfile, s = forward from stage s output
//   id_stall_flag   hold IF/ID, inject a bubble into ID/EX
//   stall_cycles    saturating stall-cycle counter
module id_hazard_scoreboard #(
   parameter int unsigned NUM_SRC         = 2,
   parameter int unsigned DEPTH           = 3,
   parameter int unsigned LD_READY_STAGE  = 2,
   parameter int unsigned MUL_READY_STAGE = 2,
   parameter int unsigned CNT_W           = 32,
   parameter int unsigned SEL_W           = $clog2(DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     id_valid_inst,
   input  logic [NUM_SRC*5-1:0]     id_src_idx,
   input  logic [NUM_SRC-1:0]       id_src_used,
   input  logic                     id_reg_wr,
   input  logic [4:0]               id_dest_idx,
   input  logic                     id_is_load,
   input  logic                     id_is_mul,
   input  logic                     pipe_hold,
   input  logic                     flush,
   output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
   output logic                     id_stall_flag,
   output logic [CNT_W-1:0]         stall_cycles
);

   localparam logic [SEL_W-1:0] LD_RDY  = SEL_W'(LD_READY_STAGE);
   localparam logic [SEL_W-1:0] MUL_RDY = SEL_W'(MUL_READY_STAGE);
   localparam logic [SEL_W-1:0] ALU_RDY = SEL_W'(1);

   // Index 0 holds stage 1 (EX), index DEPTH-1 holds the oldest stage.
   logic             ent_valid [DEPTH];
   logic [4:0]       ent_dest  [DEPTH];
   logic [SEL_W-1:0] ent_rdy   [DEPTH];

   logic [NUM_SRC-1:0] src_stall;
   logic               alloc;
   logic               cnt_inc;
   logic [SEL_W-1:0]   new_rdy;

   // Per-source youngest-match search and the resulting forward-or-stall decision.
   always_comb begin
      fwd_sel   = '0;
      src_stall = '0;
      for (int k = 0; k < int'(NUM_SRC); k++) begin : g_src
         logic [4:0]       src;
         logic             hit;
         logic [SEL_W-1:0] hit_stage;
         logic [SEL_W-1:0] hit_rdy;
         src       = id_src_idx[5*k +: 5];
         hit       = 1'b0;
         hit_stage = '0;
         hit_rdy   = '0;
         // Scan oldest to youngest so the youngest match wins.
         for (int s = int'(DEPTH) - 1; s >= 0; s--) begin
            if (id_valid_inst && id_src_used[k] && (src != 5'd0) &&
                ent_valid[s] && (ent_dest[s] == src)) begin
               hit       = 1'b1;
               hit_stage = SEL_W'(s + 1);
               hit_rdy   = ent_rdy[s];
            end
         end
         if (hit) begin
            if (hit_stage >= hit_rdy) fwd_sel[k*SEL_W +: SEL_W] = hit_stage;
            else                      src_stall[k] = 1'b1;
         end
      end
   end

   assign id_stall_flag = |src_stall;

   assign alloc   = id_valid_inst && id_reg_wr && (id_dest_idx != 5'd0) &&
                    !id_stall_flag && !flush;
   assign cnt_inc = id_stall_flag && id_valid_inst && !pipe_hold && !flush;
   assign new_rdy = id_is_load ? LD_RDY : (id_is_mul ? MUL_RDY : ALU_RDY);

   // Scoreboard shift and stall counter; hold freezes everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < int'(DEPTH); s++) begin
            ent_valid[s] <= 1'b0;
            ent_dest[s]  <= 5'd0;
            ent_rdy[s]   <= '0;
         end
         stall_cycles <= '0;
      end else if (!pipe_hold) begin
         for (int s = 1; s < int'(DEPTH); s++) begin
            ent_valid[s] <= ent_valid[s-1];
            ent_dest[s]  <= ent_dest[s-1];
            ent_rdy[s]   <= ent_rdy[s-1];
         end
         ent_valid[0] <= alloc;
         ent_dest[0]  <= id_dest_idx;
         ent_rdy[0]   <= new_rdy;
         if (cnt_inc && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb_id_hazard_scoreboard
// Directed bench for id_hazard_scoreboard. A queue-based model of in-flight
// instructions is checked against two DUT instances every cycle. The second
// instance has a narrow counter so that saturation can be reached.
module tb_id_hazard_scoreboard;

   localparam int unsigned NS   = 2;
   localparam int unsigned D    = 3;
   localparam int unsigned LDR  = 2;
   localparam int unsigned MULR = 3;
   localparam int unsigned SW   = 2;
   localparam int unsigned CW   = 32;
   localparam int unsigned CWS  = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            id_valid_inst;
   logic [NS*5-1:0] id_src_idx;
   logic [NS-1:0]   id_src_used;
   logic            id_reg_wr;
   logic [4:0]      id_dest_idx;
   logic            id_is_load;
   logic            id_is_mul;
   logic            pipe_hold;
   logic            flush;

   logic [NS*SW-1:0] fwd_sel,   fwd_sel_s;
   logic             id_stall_flag, stall_s;
   logic [CW-1:0]    stall_cycles;
   logic [CWS-1:0]   stall_cycles_s;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   id_hazard_scoreboard #(.NUM_SRC(NS), .DEPTH(D), .LD_READY_STAGE(LDR),
                          .MUL_READY_STAGE(MULR), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_valid_inst(id_valid_inst), .id_src_idx(id_src_idx),
      .id_src_used(id_src_used), .id_reg_wr(id_reg_wr), .id_dest_idx(id_dest_idx),
      .id_is_load(id_is_load), .id_is_mul(id_is_mul), .pipe_hold(pipe_hold),
      .flush(flush), .fwd_sel(fwd_sel), .id_stall_flag(id_stall_flag),
      .stall_cycles(stall_cycles));

   id_hazard_scoreboard #(.NUM_SRC(NS), .DEPTH(D), .LD_READY_STAGE(LDR),
                          .MUL_READY_STAGE(MULR), .CNT_W(CWS)) dut_sat (
      .clk(clk), .rst(rst), .id_valid_inst(id_valid_inst), .id_src_idx(id_src_idx),
      .id_src_used(id_src_used), .id_reg_wr(id_reg_wr), .id_dest_idx(id_dest_idx),
      .id_is_load(id_is_load), .id_is_mul(id_is_mul), .pipe_hold(pipe_hold),
      .flush(flush), .fwd_sel(fwd_sel_s), .id_stall_flag(stall_s),
      .stall_cycles(stall_cycles_s));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- model: list of in-flight writers with their age ----------
   typedef struct {
      int stage;
      int dest;
      int rdy;
   } ent_t;

   ent_t   q[$];
   ent_t   nq[$];
   ent_t   ne;
   longint cm = 0;
   int     cs = 0;
   bit     started = 0;
   logic [NS*SW-1:0] mf, ef;
   logic             mst, est;

   function automatic void model_eval(output logic [NS*SW-1:0] f, output logic st);
      f  = '0;
      st = 1'b0;
      for (int k = 0; k < int'(NS); k++) begin
         int src;
         int best;
         int brdy;
         src  = int'(id_src_idx[5*k +: 5]);
         best = 0;
         brdy = 0;
         if (id_valid_inst && id_src_used[k] && src != 0) begin
            foreach (q[i])
               if (q[i].dest == src && (best == 0 || q[i].stage < best)) begin
                  best = q[i].stage;
                  brdy = q[i].rdy;
               end
            if (best != 0) begin
               if (best >= brdy) f[k*SW +: SW] = SW'(best);
               else              st = 1'b1;
            end
         end
      end
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         cm = 0;
         cs = 0;
         started = 1;
      end else if (!pipe_hold) begin
         model_eval(mf, mst);
         nq.delete();
         foreach (q[i])
            if (q[i].stage + 1 <= int'(D)) begin
               ne = q[i];
               ne.stage = ne.stage + 1;
               nq.push_back(ne);
            end
         if (id_valid_inst && id_reg_wr && id_dest_idx != 5'd0 && !mst && !flush) begin
            ne.stage = 1;
            ne.dest  = int'(id_dest_idx);
            ne.rdy   = id_is_load ? int'(LDR) : (id_is_mul ? int'(MULR) : 1);
            nq.push_back(ne);
         end
         q = nq;
         if (mst && id_valid_inst && !flush) begin
            if (cm < 64'hFFFF_FFFF) cm = cm + 1;
            if (cs < 7) cs = cs + 1;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (started) begin
         model_eval(ef, est);
         chk("fwd_sel", 64'(fwd_sel), 64'(ef));
         chk("stall", 64'(id_stall_flag), 64'(est));
         chk("stall_cycles", 64'(stall_cycles), 64'(cm));
         chk("fwd_sel_sat", 64'(fwd_sel_s), 64'(ef));
         chk("stall_cycles_sat", 64'(stall_cycles_s), 64'(cs));
      end
   end

   // ---------------- stimulus --------------------------------------------------
   task automatic step(input logic v, input int s0, input int s1, input logic [1:0] u,
                       input logic wr, input int d, input logic ld, input logic mul,
                       input logic hold, input logic fl, input logic r);
      @(posedge clk);
      #1;
      rst           = r;
      id_valid_inst = v;
      id_src_idx    = {5'(s1), 5'(s0)};
      id_src_used   = u;
      id_reg_wr     = wr;
      id_dest_idx   = 5'(d);
      id_is_load    = ld;
      id_is_mul     = mul;
      pipe_hold     = hold;
      flush         = fl;
      @(negedge clk);
   endtask

   task automatic idle(input logic r);
      step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, r);
   endtask

   task automatic user(input int s0, input int s1, input logic [1:0] u, input logic hold);
      step(1, s0, s1, u, 0, 0, 0, 0, hold, 0, 0);
   endtask

   task automatic alu(input int d);
      step(1, 0, 0, 2'b00, 1, d, 0, 0, 0, 0, 0);
   endtask

   task automatic load(input int d);
      step(1, 0, 0, 2'b00, 1, d, 1, 0, 0, 0, 0);
   endtask

   task automatic mult(input int d);
      step(1, 0, 0, 2'b00, 1, d, 0, 1, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; id_valid_inst = 1'b0; id_src_idx = '0; id_src_used = '0;
      id_reg_wr = 1'b0; id_dest_idx = '0; id_is_load = 1'b0; id_is_mul = 1'b0;
      pipe_hold = 1'b0; flush = 1'b0;

      idle(1);
      idle(1);
      chk("rst_fwd", 64'(fwd_sel), 64'h0);
      chk("rst_stall", 64'(id_stall_flag), 64'h0);
      chk("rst_cnt", 64'(stall_cycles), 64'h0);

      // ALU result walks EX -> MEM -> WB, then retires
      alu(5);
      user(5, 0, 2'b01, 0); chk("add_s1", 64'(fwd_sel), 64'h1);
                            chk("add_s1_stall", 64'(id_stall_flag), 64'h0);
      user(5, 0, 2'b01, 0); chk("add_s2", 64'(fwd_sel), 64'h2);
      user(5, 0, 2'b01, 0); chk("add_s3", 64'(fwd_sel), 64'h3);
      user(5, 0, 2'b01, 0); chk("add_retired", 64'(fwd_sel), 64'h0);

      // load-use: one stall cycle
      load(7);
      user(7, 0, 2'b01, 0); chk("lw_stall", 64'(id_stall_flag), 64'h1);
      user(7, 0, 2'b01, 0); chk("lw_fwd", 64'(fwd_sel), 64'h2);
                            chk("lw_cnt", 64'(stall_cycles), 64'd1);

      // multiply ready at stage 3: two stall cycles
      mult(9);
      user(9, 0, 2'b01, 0); chk("mul_stall1", 64'(id_stall_flag), 64'h1);
      user(9, 0, 2'b01, 0); chk("mul_stall2", 64'(id_stall_flag), 64'h1);
      user(9, 0, 2'b01, 0); chk("mul_fwd", 64'(fwd_sel), 64'h3);
                            chk("mul_cnt", 64'(stall_cycles), 64'd3);

      // youngest writer (load) governs over older ALU write
      alu(4);
      load(4);
      user(4, 0, 2'b01, 0); chk("young_stall", 64'(id_stall_flag), 64'h1);
      user(0, 4, 2'b10, 0); chk("young_fwd_src1", 64'(fwd_sel), 64'h8);
                            chk("young_cnt", 64'(stall_cycles), 64'd4);

      // hold during load-use stall freezes everything
      load(8);
      user(8, 0, 2'b01, 1);
      user(8, 0, 2'b01, 1);
      user(8, 0, 2'b01, 1); chk("hold_stall", 64'(id_stall_flag), 64'h1);
                            chk("hold_cnt", 64'(stall_cycles), 64'd4);
      user(8, 0, 2'b01, 0); chk("hold_rel_stall", 64'(id_stall_flag), 64'h1);
      user(8, 0, 2'b01, 0); chk("hold_rel_fwd", 64'(fwd_sel), 64'h2);
                            chk("hold_rel_cnt", 64'(stall_cycles), 64'd5);

      // flushed writer never allocates
      step(1, 0, 0, 2'b00, 1, 3, 0, 0, 0, 1, 0);
      user(3, 0, 2'b01, 0); chk("flush_fwd", 64'(fwd_sel), 64'h0);

      // invalid instruction, unused source, x0 source never stall
      load(10);
      step(0, 10, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
      chk("invalid_nostall", 64'(id_stall_flag), 64'h0);
      load(20);
      user(0, 20, 2'b01, 0); chk("unused_nostall", 64'(id_stall_flag), 64'h0);
      load(0);
      user(0, 0, 2'b11, 0); chk("x0_nostall", 64'(id_stall_flag), 64'h0);
                            chk("x0_fwd", 64'(fwd_sel), 64'h0);

      // two sources matched independently
      alu(11);
      alu(12);
      user(11, 12, 2'b11, 0); chk("dual_fwd", 64'(fwd_sel), 64'h6);

      // drive the narrow counter into saturation
      mult(14);
      user(14, 0, 2'b01, 0);
      user(14, 0, 2'b01, 0);
      user(14, 0, 2'b01, 0);
      mult(15);
      user(0, 15, 2'b10, 0);
      user(0, 15, 2'b10, 0);
      user(0, 15, 2'b10, 0); chk("sat_cnt", 64'(stall_cycles_s), 64'd7);
                             chk("wide_cnt", 64'(stall_cycles), 64'd9);

      // stall while flushed does not count
      load(17);
      step(1, 17, 0, 2'b01, 0, 0, 0, 0, 0, 1, 0);
      chk("flush_stall_flag", 64'(id_stall_flag), 64'h1);
      user(17, 0, 2'b01, 0); chk("flush_no_count", 64'(stall_cycles), 64'd9);

      // reset in the middle of a stall
      load(16);
      user(16, 0, 2'b01, 0);
      step(1, 16, 0, 2'b01, 0, 0, 0, 0, 0, 0, 1);
      user(16, 0, 2'b01, 0); chk("rst_mid_stall", 64'(id_stall_flag), 64'h0);
                             chk("rst_mid_cnt", 64'(stall_cycles), 64'h0);
      idle(0);
      idle(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
